// File: rtl/shifter_spi_arbiter_if.sv
// Shared ISA types and the Spi bus used between the arbiter (master) and the BarrelShifter (slave).
package Isa;
  localparam int REGISTER_SIZE = 8;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4,
    SHL = 3'd5,
    SHR = 3'd6,
    NOP = 3'd7
  } Operation;

  // The first field is the most significant, so op_code occupies the lowest bits and goes out first.
  typedef struct packed {
    logic [$clog2(REGISTER_SIZE)-1:0] amount;
    logic [REGISTER_SIZE-1:0]         operand;
    Operation                         op_code;
  } ShifterPacket;
endpackage

interface Spi #(
  parameter int NSS_WIDTH = 1
);
  logic [NSS_WIDTH-1:0] nss;
  logic                 mosi;
  logic                 miso;

  modport MasterSpi (output nss, output mosi, input miso);
  modport SlaveSpi  (input nss, input mosi, output miso);
endinterface

// File: rtl/shifter_spi_arbiter.sv
// Round-robin arbiter plus SPI master that serialises one shift request at a time to a shared BarrelShifter.
// Optional feature: define SHIFTER_TIMEOUT_EN to abandon WAIT_RESULT after TIMEOUT_CYCLES and flag o_error.
module shifter_spi_arbiter
  import Isa::*;
#(
  parameter int N_REQ          = 2,
  parameter int NSS_WIDTH      = 1,
  parameter int NSS_POSITION   = 0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic [N_REQ-1:0]                 i_req,
  input  Operation                         i_op_code [N_REQ],
  input  logic [REGISTER_SIZE-1:0]         i_operand [N_REQ],
  input  logic [$clog2(REGISTER_SIZE)-1:0] i_amount  [N_REQ],
  output logic [N_REQ-1:0]                 o_ack,
  output logic [N_REQ-1:0]                 o_done,
  output logic [REGISTER_SIZE-1:0]         o_result,
  output logic                             o_busy,
  output logic                             o_error,
  Spi.MasterSpi                            spi
);

  localparam int R       = REGISTER_SIZE;
  localparam int P       = $bits(ShifterPacket);
  localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BIT_W   = $clog2(P);
  localparam int PR_MAX  = (P > R) ? P : R;
  localparam int CNT_MAX = (PR_MAX > TIMEOUT_CYCLES) ? PR_MAX : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [NSS_WIDTH-1:0] NSS_SEL = ~(NSS_WIDTH'(1) << NSS_POSITION);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_TRANSMIT,
    S_WAIT_RESULT,
    S_COLLECT,
    S_RELEASE
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_owner;
  ShifterPacket       r_packet;
  ShifterPacket       w_packet;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [R-2:0]       r_shift;
  logic [R-1:0]       r_result;
  logic               w_grant_valid;
  logic [PTR_W-1:0]   w_grant_idx;
  logic [PTR_W-1:0]   w_cand;
  logic [NSS_WIDTH-1:0] w_nss;
  logic               w_mosi;
`ifdef SHIFTER_TIMEOUT_EN
  logic               r_timed_out;
`endif

  // Scan from the pointer upwards with wrap; the lowest offset that requests wins.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no path can infer a latch.
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    w_cand        = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      w_cand = PTR_W'((int'(r_ptr) + j) % N_REQ);
      if (i_req[w_cand]) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = w_cand;
      end
    end
  end

  assign w_packet = '{amount:  i_amount[w_grant_idx],
                      operand: i_operand[w_grant_idx],
                      op_code: i_op_code[w_grant_idx]};

  always_comb begin
    w_state_next = r_state;
    o_ack        = '0;
    o_done       = '0;
    w_nss        = '1;
    w_mosi       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant_valid) begin
          o_ack[w_grant_idx] = 1'b1;
          w_state_next       = S_START;
        end
      end
      S_START: begin
        w_nss        = NSS_SEL;
        w_mosi       = 1'b1;
        w_state_next = S_TRANSMIT;
      end
      S_TRANSMIT: begin
        w_nss  = NSS_SEL;
        w_mosi = r_packet[r_bit_cnt[BIT_W-1:0]];
        if (r_bit_cnt == CNT_W'(P - 1)) w_state_next = S_WAIT_RESULT;
      end
      S_WAIT_RESULT: begin
        w_nss = NSS_SEL;
        if (spi.miso) w_state_next = S_COLLECT;
`ifdef SHIFTER_TIMEOUT_EN
        else if (r_bit_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) w_state_next = S_RELEASE;
`endif
      end
      S_COLLECT: begin
        w_nss = NSS_SEL;
        if (r_bit_cnt == CNT_W'(R - 1)) w_state_next = S_RELEASE;
      end
      S_RELEASE: begin
        o_done[r_owner] = 1'b1;
        w_state_next    = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // One counter serves TRANSMIT bit index, WAIT_RESULT timeout and COLLECT bit index; it restarts on every state change.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_packet    <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_result    <= '0;
`ifdef SHIFTER_TIMEOUT_EN
      r_timed_out <= 1'b0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      r_state   <= w_state_next;
      r_bit_cnt <= (w_state_next != r_state) ? '0 : r_bit_cnt + 1'b1;
      if (r_state == S_IDLE && w_grant_valid) begin
        r_owner  <= w_grant_idx;
        r_ptr    <= (w_grant_idx == PTR_W'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
        r_packet <= w_packet;
`ifdef SHIFTER_TIMEOUT_EN
        r_timed_out <= 1'b0;
`endif
      end
      if (r_state == S_COLLECT) begin
        r_shift <= {spi.miso, r_shift[R-2:1]};
        if (w_state_next == S_RELEASE) r_result <= {spi.miso, r_shift};
      end
`ifdef SHIFTER_TIMEOUT_EN
      if (r_state == S_WAIT_RESULT && w_state_next == S_RELEASE) begin
        r_result    <= '0;
        r_timed_out <= 1'b1;
      end
`endif
    end
  end

  assign spi.nss  = w_nss;
  assign spi.mosi = w_mosi;
  assign o_result = r_result;
  assign o_busy   = (r_state != S_IDLE);
`ifdef SHIFTER_TIMEOUT_EN
  assign o_error  = (r_state == S_RELEASE) && r_timed_out;
`else
  assign o_error  = 1'b0;
`endif

endmodule

// File: tb/tb_shifter_spi_arbiter.sv
// Bench for shifter_spi_arbiter: behavioural BarrelShifter slave on the Spi bus plus a result scoreboard.
module tb_shifter_spi_arbiter;
  import Isa::*;

  localparam int N_REQ    = 2;
  localparam int R        = REGISTER_SIZE;
  localparam int P        = $bits(ShifterPacket);
  localparam int T        = 4;
  localparam int DONE_CYC = P + R + 4;

  typedef struct {
    int             idx;
    logic [R-1:0]   result;
    logic           error;
  } exp_t;

  exp_t sb[$];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [N_REQ-1:0] req = '0;
  Operation                 op_code [N_REQ];
  logic [R-1:0]             operand [N_REQ];
  logic [$clog2(R)-1:0]     amount  [N_REQ];
  logic [N_REQ-1:0] ack, done;
  logic [R-1:0]     result;
  logic             busy, error;
  int n_checks = 0;
  int n_fail   = 0;
  bit slave_en = 1'b1;

  Spi #(.NSS_WIDTH(1)) spi_bus ();

  shifter_spi_arbiter #(
    .N_REQ(N_REQ), .NSS_WIDTH(1), .NSS_POSITION(0), .TIMEOUT_CYCLES(T)
  ) dut (
    .i_clock(clk), .i_reset(rst_n), .i_req(req), .i_op_code(op_code),
    .i_operand(operand), .i_amount(amount), .o_ack(ack), .o_done(done),
    .o_result(result), .o_busy(busy), .o_error(error), .spi(spi_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  // Reference rotate: SHL/SHR rotate by amount, anything else yields 0.
  function automatic logic [R-1:0] model(input Operation op, input logic [R-1:0] x, input int a);
    logic [R-1:0] y;
    y = '0;
    for (int i = 0; i < R; i++) begin
      if (op == SHL)      y[(i + a) % R]     = x[i];
      else if (op == SHR) y[(i + R - a) % R] = x[i];
    end
    return y;
  endfunction

  // Slave: idx counts selected cycles; start bit, P packet bits, marker, then R result bits LSB first.
  int unsigned    s_idx;
  logic [P-1:0]   s_pkt;
  ShifterPacket   s_sp;
  logic [R-1:0]   s_res;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_idx = 0;
      spi_bus.miso <= 1'b0;
    end else if (spi_bus.nss[0]) begin
      n_checks++;
      if (spi_bus.mosi !== 1'b0) begin
        n_fail++;
        $display("FAIL mosi_idle: mosi=%b while nss high, required 0", spi_bus.mosi);
      end
      s_idx = 0;
      spi_bus.miso <= 1'b0;
    end else begin
      if (s_idx == 0) begin
        n_checks++;
        if (spi_bus.mosi !== 1'b1) begin
          n_fail++;
          $display("FAIL start_bit: mosi=%b, required 1", spi_bus.mosi);
        end
      end else if (s_idx <= P) begin
        s_pkt[s_idx-1] = spi_bus.mosi;
      end else begin
        n_checks++;
        if (spi_bus.mosi !== 1'b0) begin
          n_fail++;
          $display("FAIL mosi_after_packet: mosi=%b at slot %0d, required 0", spi_bus.mosi, s_idx);
        end
      end
      if (slave_en) begin
        if (s_idx == P + 1) begin
          s_sp  = s_pkt;
          s_res = model(s_sp.op_code, s_sp.operand, int'(s_sp.amount));
          spi_bus.miso <= 1'b1;
        end else if (s_idx >= P + 2 && s_idx < P + 2 + R) begin
          spi_bus.miso <= s_res[s_idx-P-2];
        end else begin
          spi_bus.miso <= 1'b0;
        end
      end
      s_idx++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents one request at a negedge and returns the ack seen in that cycle; optionally drops it after the edge.
  task automatic issue(input int idx, input Operation op, input logic [R-1:0] x, input int a,
                       output logic [N_REQ-1:0] ack_seen);
    @(negedge clk);
    op_code[idx] = op;
    operand[idx] = x;
    amount[idx]  = a[$clog2(R)-1:0];
    req[idx]     = 1'b1;
    #1 ack_seen  = ack;
    @(posedge clk);
    #1 req[idx] = 1'b0;
  endtask

  // Samples each negedge until a done pulse appears or the budget runs out; n is the cycle index since ack.
  task automatic wait_done(input int max_cyc, output int n, output bit found,
                           output logic [N_REQ-1:0] d, output logic [R-1:0] r, output logic e);
    n = 0; found = 1'b0; d = '0; r = '0; e = 1'b0;
    while (!found && n < max_cyc) begin
      @(negedge clk);
      #1 n++;
      if (done !== '0) begin
        found = 1'b1; d = done; r = result; e = error;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    n_checks++; if (ack !== '0)       begin n_fail++; $display("FAIL reset_ack: got %b, required 0", ack); end
    n_checks++; if (done !== '0)      begin n_fail++; $display("FAIL reset_done: got %b, required 0", done); end
    n_checks++; if (result !== '0)    begin n_fail++; $display("FAIL reset_result: got %h, required 0", result); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_checks++; if (error !== 1'b0)   begin n_fail++; $display("FAIL reset_error: got %b, required 0", error); end
    n_checks++; if (spi_bus.nss !== 1'b1)  begin n_fail++; $display("FAIL reset_nss: got %b, required 1", spi_bus.nss); end
    n_checks++; if (spi_bus.mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b, required 0", spi_bus.mosi); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [N_REQ-1:0] a, d; logic [R-1:0] r; logic e; int n; bit f; exp_t x;
    issue(0, SHL, 8'h81, 1, a);
    n_checks++; if (a !== 2'b01) begin n_fail++; $display("FAIL single_ack: got %b, required 01", a); end
    sb.push_back('{0, model(SHL, 8'h81, 1), 1'b0});
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b, required 1", busy); end
    wait_done(200, n, f, d, r, e);
    n_checks++;
    if (!f || sb.size() == 0) begin
      n_fail++; $display("FAIL single_no_done: no done within budget");
    end else begin
      x = sb.pop_front();
      if (d !== 2'b01 || r !== x.result || r !== 8'h03 || e !== x.error || n != DONE_CYC) begin
        n_fail++;
        $display("FAIL single_done: done=%b result=%h error=%b cycle=%0d, required 01/03/0/%0d", d, r, e, n, DONE_CYC);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (done !== '0 || result !== 8'h03 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_hold: done=%b result=%h busy=%b, required 00/03/0", done, result, busy);
    end
  endtask

  task automatic test_ops();
    int       t_idx [4] = '{1, 1, 0, 0};
    Operation t_op  [4] = '{SHR, SHL, ADD, SHR};
    logic [R-1:0] t_x [4] = '{8'h01, 8'hA5, 8'h5A, 8'h96};
    int       t_a   [4] = '{1, 0, 3, 3};
    logic [R-1:0] t_lit [4] = '{8'h80, 8'hA5, 8'h00, 8'hD2};
    logic [N_REQ-1:0] a, d; logic [R-1:0] r; logic e; int n; bit f; exp_t x;
    for (int i = 0; i < 4; i++) begin
      issue(t_idx[i], t_op[i], t_x[i], t_a[i], a);
      n_checks++;
      if (a !== (N_REQ'(1) << t_idx[i])) begin
        n_fail++; $display("FAIL ops_ack[%0d]: got %b for requester %0d", i, a, t_idx[i]);
      end
      sb.push_back('{t_idx[i], model(t_op[i], t_x[i], t_a[i]), 1'b0});
      wait_done(200, n, f, d, r, e);
      n_checks++;
      if (!f || sb.size() == 0) begin
        n_fail++; $display("FAIL ops_no_done[%0d]: no done within budget", i);
      end else begin
        x = sb.pop_front();
        if (d !== (N_REQ'(1) << x.idx) || r !== x.result || r !== t_lit[i] || e !== 1'b0 || n != DONE_CYC) begin
          n_fail++;
          $display("FAIL ops_done[%0d]: done=%b result=%h error=%b cycle=%0d, required result %h cycle %0d",
                   i, d, r, e, n, t_lit[i], DONE_CYC);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N_REQ-1:0] d; logic [R-1:0] r; logic e; int n, w; bit f; exp_t x; int g;
    do_reset();
    op_code[0] = SHL; operand[0] = 8'h3C; amount[0] = 3'd2;
    op_code[1] = SHR; operand[1] = 8'hC3; amount[1] = 3'd5;
    @(negedge clk);
    req = 2'b11;
    #1;
    for (int t = 0; t < 4; t++) begin
      w = 0;
      while (ack === '0 && w < 8) begin
        @(negedge clk); #1 w++;
      end
      g = t % 2;
      n_checks++;
      if (ack !== (N_REQ'(1) << g) || spi_bus.nss !== 1'b1) begin
        n_fail++; $display("FAIL b2b_grant[%0d]: ack=%b nss=%b, required requester %0d with nss 1", t, ack, spi_bus.nss, g);
      end
      sb.push_back('{g, model(op_code[g], operand[g], int'(amount[g])), 1'b0});
      wait_done(200, n, f, d, r, e);
      if (t == 3) req = '0;
      n_checks++;
      if (!f || sb.size() == 0) begin
        n_fail++; $display("FAIL b2b_no_done[%0d]: no done within budget", t);
      end else begin
        x = sb.pop_front();
        if (d !== (N_REQ'(1) << x.idx) || r !== x.result || e !== 1'b0 || spi_bus.nss !== 1'b1 || n != DONE_CYC) begin
          n_fail++;
          $display("FAIL b2b_done[%0d]: done=%b result=%h nss=%b cycle=%0d, required idx %0d result %h",
                   t, d, r, spi_bus.nss, n, x.idx, x.result);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [N_REQ-1:0] a, d; logic [R-1:0] r; logic e; int n; bit f; exp_t x;
    issue(0, SHL, 8'h81, 1, a);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (spi_bus.nss !== 1'b1 || spi_bus.mosi !== 1'b0 || busy !== 1'b0 || done !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: nss=%b mosi=%b busy=%b done=%b, required 1/0/0/00", spi_bus.nss, spi_bus.mosi, busy, done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_done(40, n, f, d, r, e);
    n_checks++; if (f) begin n_fail++; $display("FAIL midreset_spurious_done: done=%b at cycle %0d, required none", d, n); end
    issue(1, SHR, 8'h01, 1, a);
    n_checks++; if (a !== 2'b10) begin n_fail++; $display("FAIL midreset_ack: got %b, required 10", a); end
    sb.push_back('{1, model(SHR, 8'h01, 1), 1'b0});
    wait_done(200, n, f, d, r, e);
    n_checks++;
    if (!f || sb.size() == 0) begin
      n_fail++; $display("FAIL midreset_no_done: no done within budget");
    end else begin
      x = sb.pop_front();
      if (d !== 2'b10 || r !== x.result || r !== 8'h80 || e !== 1'b0 || n != DONE_CYC) begin
        n_fail++; $display("FAIL midreset_done: done=%b result=%h cycle=%0d, required 10/80/%0d", d, r, n, DONE_CYC);
      end
    end
  endtask

  task automatic test_timeout();
    logic [N_REQ-1:0] a, d; logic [R-1:0] r; logic e; int n; bit f;
`ifdef SHIFTER_TIMEOUT_EN
    exp_t x;
`endif
    slave_en = 1'b0;
    issue(0, SHL, 8'h81, 1, a);
    n_checks++; if (a !== 2'b01) begin n_fail++; $display("FAIL timeout_ack: got %b, required 01", a); end
`ifdef SHIFTER_TIMEOUT_EN
    sb.push_back('{0, '0, 1'b1});
    wait_done(60, n, f, d, r, e);
    n_checks++;
    if (!f || sb.size() == 0) begin
      n_fail++; $display("FAIL timeout_no_done: no done within budget");
    end else begin
      x = sb.pop_front();
      if (d !== 2'b01 || r !== x.result || e !== x.error || n != P + 2 + T) begin
        n_fail++; $display("FAIL timeout_done: done=%b result=%h error=%b cycle=%0d, required 01/00/1/%0d", d, r, e, n, P + 2 + T);
      end
    end
    @(negedge clk); #1;
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL timeout_error_pulse: got %b, required 0", error); end
    slave_en = 1'b1;
`else
    wait_done(60, n, f, d, r, e);
    n_checks++; if (f) begin n_fail++; $display("FAIL wait_spurious_done: done=%b at cycle %0d, required none", d, n); end
    n_checks++;
    if (busy !== 1'b1 || error !== 1'b0 || spi_bus.nss !== 1'b0) begin
      n_fail++; $display("FAIL wait_hold: busy=%b error=%b nss=%b, required 1/0/0", busy, error, spi_bus.nss);
    end
    do_reset();
    slave_en = 1'b1;
`endif
  endtask

  initial begin
    for (int i = 0; i < N_REQ; i++) begin
      op_code[i] = NOP;
      operand[i] = '0;
      amount[i]  = '0;
    end
    test_reset();
    test_single();
    test_ops();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: %0d entries, required 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
